// File: rtl/decomposition_rx.sv
// decomposition_rx: captures a pair of SIZE_N-element fp_double vectors on the
// rising edge of in_valid, scans the second vector for its largest-magnitude
// element (one element per cycle), then streams the element pairs out over a
// valid/ready handshake.
//
// Optional feature macro: DECOMP_RX_OVERRUN_EN adds a sticky `overrun` output
// flagging in_valid rises that arrived while a capture was still in progress.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous, active-low reset
//   in_valid       level "vectors valid"; a 0->1 transition in IDLE captures
//   first_vector   SIZE_N x 64-bit initial vector
//   second_vector  SIZE_N x 64-bit matrix-times-vector result
//   out_valid      element pair presented
//   out_ready      downstream accepts the presented pair
//   out_index      index of the presented pair
//   out_first      presented first_vector element
//   out_second     presented second_vector element
//   out_last       presented pair is index SIZE_N-1
//   max_index      index of largest |second_vector| element
//   max_valid      max_index valid for the current capture
//   overrun        (DECOMP_RX_OVERRUN_EN only) sticky ignored-rise flag
//   busy           high while scanning or streaming
module decomposition_rx #(
  parameter int unsigned SIZE_N = 8,
  localparam int unsigned IW = $clog2(SIZE_N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [SIZE_N-1:0][63:0]  first_vector,
  input  logic [SIZE_N-1:0][63:0]  second_vector,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_index,
  output logic [63:0]              out_first,
  output logic [63:0]              out_second,
  output logic                     out_last,
  output logic [IW-1:0]            max_index,
  output logic                     max_valid,
`ifdef DECOMP_RX_OVERRUN_EN
  output logic                     overrun,
`endif
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StScan, StStream} state_e;

  state_e                    state_q, state_d;
  logic                      in_valid_q;
  logic [IW-1:0]             cnt_q, cnt_d;
  logic [SIZE_N-1:0][63:0]   first_q, first_d;
  logic [SIZE_N-1:0][63:0]   second_q, second_d;
  logic [IW-1:0]             cand_idx_q, cand_idx_d;
  logic [62:0]               cand_mag_q, cand_mag_d;
  logic [IW-1:0]             max_index_q, max_index_d;
  logic                      max_valid_q, max_valid_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overrun_q, overrun_d;

  logic                      rise;
  logic                      cnt_last;
  logic [62:0]               cur_mag;
  logic [IW-1:0]             new_idx;
  logic [62:0]               new_mag;

  assign rise     = in_valid & ~in_valid_q;
  assign cnt_last = (cnt_q == IW'(SIZE_N - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    second_d    = second_q;
    cand_idx_d  = cand_idx_q;
    cand_mag_d  = cand_mag_q;
    max_index_d = max_index_q;
    max_valid_d = max_valid_q;
    out_valid_d = out_valid_q;
    // Sign bit dropped: bits [62:0] of an IEEE double order by magnitude.
    cur_mag     = second_q[cnt_q][62:0];
    new_idx     = cand_idx_q;
    new_mag     = cand_mag_q;
    // Ties keep the earlier index because only a strictly larger value wins.
    if ((cnt_q == '0) || (cur_mag > cand_mag_q)) begin
      new_idx = cnt_q;
      new_mag = cur_mag;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          first_d     = first_vector;
          second_d    = second_vector;
          max_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        cand_idx_d = new_idx;
        cand_mag_d = new_mag;
        if (cnt_last) begin
          max_index_d = new_idx;
          max_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StStream;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStream: begin
        // out_valid is registered, so the first pair appears one cycle after
        // entering STREAM.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          if (cnt_last) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    overrun_d = overrun_q | (rise & (state_q != StIdle));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      in_valid_q  <= 1'b0;
      cnt_q       <= '0;
      first_q     <= '0;
      second_q    <= '0;
      cand_idx_q  <= '0;
      cand_mag_q  <= '0;
      max_index_q <= '0;
      max_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_valid_q  <= in_valid;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      second_q    <= second_d;
      cand_idx_q  <= cand_idx_d;
      cand_mag_q  <= cand_mag_d;
      max_index_q <= max_index_d;
      max_valid_q <= max_valid_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Data outputs are gated so everything reads zero when nothing is presented.
  assign out_valid  = out_valid_q;
  assign out_index  = out_valid_q ? cnt_q : '0;
  assign out_first  = out_valid_q ? first_q[cnt_q] : '0;
  assign out_second = out_valid_q ? second_q[cnt_q] : '0;
  assign out_last   = out_valid_q & cnt_last;
  assign max_index  = max_index_q;
  assign max_valid  = max_valid_q;
  assign busy       = (state_q != StIdle);

`ifdef DECOMP_RX_OVERRUN_EN
  assign overrun = overrun_q;
`else
  // Ignored rises are silent in this build.
  logic unused_overrun;
  assign unused_overrun = overrun_q;
`endif

endmodule

// File: doc/decomposition_rx.md
DECOMPOSITION_RX -- requirements
Module: decomposition_rx

Interface
REQ-001 SHALL have parameter: SIZE_N, 8, vector length (≥2); IW = $clog2(SIZE_N) is derived.
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  in  1  level "vectors valid" from the vector-producing stage.
REQ-005 SHALL have port: first_vector  in  double[SIZE_N][1]  initial vector, fp_double format.
REQ-006 SHALL have port: second_vector  in  double[SIZE_N][1]  matrix-times-vector result, fp_double format.
REQ-007 SHALL have port: out_valid  out  1  element pair available.
REQ-008 SHALL have port: out_ready  in  1  downstream accepts element pair.
REQ-009 SHALL have port: out_index  out  IW  index of presented element.
REQ-010 SHALL have port: out_first / out_second  out  64 each  presented element of each vector.
REQ-011 SHALL have port: out_last  out  1  presented element is index SIZE_N-1.
REQ-012 SHALL have port: max_index  out  IW  index of largest-magnitude second_vector element.
REQ-013 SHALL have port: max_valid  out  1  max_index valid for current capture.
REQ-014 SHALL have port: busy  out  1  high in SCAN or STREAM.

Function
REQ-015 SHALL use FSM states IDLE, SCAN, STREAM; reset state IDLE.
REQ-016 SHALL register in_valid (in_valid_q) and detect rise = in_valid & ~in_valid_q.
REQ-017 In IDLE on rise, SHALL latch all 2*SIZE_N elements into internal registers, clear max_valid, zero the element counter, enter SCAN.
REQ-018 SCAN SHALL compare one captured second element per cycle, index 0..SIZE_N-1, using bits [62:0] as unsigned magnitude (sign ignored; NaN not handled).
REQ-019 Ties in SCAN SHALL keep the lower index; index 0 is the initial candidate.
REQ-020 After the SIZE_N-th SCAN cycle, SHALL register max_index, set max_valid, zero the counter, enter STREAM.
REQ-021 out_valid SHALL first assert exactly SIZE_N+1 cycles after the edge that latched the vectors.
REQ-022 In STREAM, out_valid=1 and out_index/out_first/out_second SHALL show element [counter]; all hold stable while out_ready=0.
REQ-023 A transfer SHALL occur when out_valid & out_ready; the counter then increments.
REQ-024 out_last SHALL equal out_valid & (counter==SIZE_N-1).
REQ-025 After the last transfer, SHALL enter IDLE with out_valid=0 next cycle; max_valid and max_index hold until the next capture.
REQ-026 A rise outside IDLE SHALL be ignored; captured data is never overwritten mid-operation.
REQ-027 in_valid held high SHALL yield exactly one capture; a new capture requires in_valid low ≥1 cycle.
REQ-028 Vector inputs SHALL be sampled only on the capture edge; later changes have no effect.

Reset
REQ-029 On rst=0, asynchronously: state IDLE, in_valid_q=0, counter=0, out_valid=0, out_last=0, out_index=0, out_first=0, out_second=0, max_index=0, max_valid=0, busy=0, overrun=0.
REQ-030 Reset during SCAN or STREAM SHALL abort; the first rise after release starts a fresh capture.

Configuration
REQ-031 With macro DECOMP_RX_OVERRUN_EN defined, SHALL add output overrun (1 bit), set sticky by a rise when state≠IDLE, cleared only by reset.
REQ-032 Without DECOMP_RX_OVERRUN_EN, the overrun port and logic SHALL be absent; ignored rises are silent.

Verification
REQ-033 SIZE_N=8, second=[1.0,-3.0,2.0,3.0,0.5,0,0,0], in_valid 0->1, out_ready=1 -> out_valid at cycle 9, 8 consecutive transfers idx 0..7, out_last at idx 7, max_index=1, max_valid=1.
REQ-034 Same data, out_ready toggling 1,0,1,0 -> out_* stable while out_ready=0, each index transferred exactly once, order 0..7.
REQ-035 in_valid held high 40 cycles -> exactly one 8-element stream; busy low after it.
REQ-036 Second rise during STREAM -> ignored, stream data unchanged; overrun=1 with DECOMP_RX_OVERRUN_EN, port absent without.
REQ-037 rst=0 at STREAM idx 3 -> all outputs 0 asynchronously; next rise after release gives full stream from idx 0.
REQ-038 second all +0.0 -> max_index=0, max_valid=1.
